alu_gate_issue: RTL and testbench
=================================

Name: alu_gate_issue

Overview:
- Sequencer that drives the logic-gate ALU datapath from the instruction side.
- Accepts one decoded logic instruction (func, rd, rs1, rs2) over a valid/ready handshake.
- Reads both source registers from the register file and presents the operands and func to the combinational gate unit.
- Captures the gate unit's result and writes it back to the register file at rd; the complete counterpart that feeds and drains the gate unit.

Parameters:
- DATA_WIDTH, 32, register and operand width.
- ADDR_WIDTH, 5, register-file address width.
- FUNC_WIDTH, 2, function code width; encodings AND=0, OR=1, XOR=2, NOT=3.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- instr_valid_i  in  1  instruction offered.
- instr_ready_o  out  1  block can accept an instruction.
- instr_func_i  in  FUNC_WIDTH  gate function.
- instr_rd_i  in  ADDR_WIDTH  destination register.
- instr_rs1_i  in  ADDR_WIDTH  source register 1.
- instr_rs2_i  in  ADDR_WIDTH  source register 2.
- rf_rs1_addr_o  out  ADDR_WIDTH  register-file read address 1.
- rf_rs2_addr_o  out  ADDR_WIDTH  register-file read address 2.
- rf_rs1_data_i  in  DATA_WIDTH  read data 1; valid one cycle after the address.
- rf_rs2_data_i  in  DATA_WIDTH  read data 2; valid one cycle after the address.
- alu_rs1_data_o  out  DATA_WIDTH  operand 1 to the gate unit.
- alu_rs2_data_o  out  DATA_WIDTH  operand 2 to the gate unit.
- alu_func_o  out  FUNC_WIDTH  function to the gate unit.
- alu_rd_data_i  in  DATA_WIDTH  combinational result from the gate unit.
- rf_we_o  out  1  register-file write enable.
- rf_wr_addr_o  out  ADDR_WIDTH  write address.
- rf_wr_data_o  out  DATA_WIDTH  write data.
- done_o  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Reset and clocking:
  - One clock, clk_i; rst_i is synchronous and active-high.
  - Under reset: state=IDLE, instr_ready_o=1, rf_we_o=0, done_o=0; all address, data and func outputs = 0.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready_o=1.
  - On instr_valid_i && instr_ready_o: latch func, rd, rs1 and rs2; drive rf_rs1_addr_o/rf_rs2_addr_o from the latched values; go to READ.
- READ:
  - instr_ready_o=0.
  - At the end of the cycle, register rf_rs1_data_i/rf_rs2_data_i into operand registers; go to EXEC.
- EXEC:
  - Drive alu_rs1_data_o, alu_rs2_data_o and alu_func_o from registers.
  - For NOT, alu_rs2_data_o=0.
  - Register alu_rd_data_i into rf_wr_data_o and rd into rf_wr_addr_o; go to WB.
- WB:
  - rf_we_o=1 and done_o=1 for exactly this cycle; go to IDLE.
- Timing:
  - Handshake at cycle N gives rf_we_o at cycle N+3.
  - instr_ready_o rises at N+4; throughput is one instruction per 4 cycles.
  - No back-to-back acceptance.
- Handshake rules:
  - Instruction inputs are ignored whenever instr_ready_o=0.
  - Holding valid high while busy must not cause a double accept.
- Output holding:
  - rf addresses, operands, func and rf_wr_addr_o/rf_wr_data_o hold their last values between instructions.
  - rf_we_o and done_o are low outside WB.
- Register aliasing:
  - rs1==rs2 and rd==rs1 need no special handling; execution is serialised, so no hazard exists.
- All four func codes are legal; there is no error path.
- Reset mid-operation (READ, EXEC or WB): abort, no write-back, no done_o, next cycle IDLE with outputs at reset values.

Optional Feature:
- Macro: ALU_GATE_ISSUE_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-wired zero; an instruction with rd==0 runs normally, but rf_we_o stays 0 in WB.
  - done_o still pulses.
- Undefined:
  - rd==0 is written like any other register.

Test Plan:
- Reset, then hold valid=0 for 5 cycles -> instr_ready_o=1, rf_we_o=0, done_o=0, all outputs 0.
- AND: r1=0xF0F0_F0F0, r2=0xFF00_FF00, rd=3 -> rf_we_o=1 at handshake+3, rf_wr_addr_o=3, rf_wr_data_o=0xF000_F000, done_o pulses once.
- OR, XOR, then NOT back-to-back with valid held high: r1=0x0000_00FF, r2=0x0000_0F0F:
  - OR gives 0x0000_0FFF.
  - XOR gives 0x0000_0FF0.
  - NOT gives 0xFFFF_FF00 with alu_rs2_data_o=0.
  - Handshakes are exactly 4 cycles apart.
- Reset asserted in EXEC -> no rf_we_o, no done_o; the next instruction completes normally.
- rd=0 XOR of r1=0x1, r2=0x3:
  - With ALU_GATE_ISSUE_ZERO_REG_EN: rf_we_o stays 0, done_o=1.
  - Without it: rf_we_o=1, rf_wr_data_o=0x2.

Source files
------------

// File: rtl/alu_gate_issue_if.sv
// Instruction, register-file and gate-unit signals of the logic-gate ALU issue sequencer.
// master = sequencer side, slave = environment (decoder, register file, gate unit).
interface alu_gate_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FUNC_WIDTH = 2
);
  logic                  instr_valid_i;
  logic                  instr_ready_o;
  logic [FUNC_WIDTH-1:0] instr_func_i;
  logic [ADDR_WIDTH-1:0] instr_rd_i;
  logic [ADDR_WIDTH-1:0] instr_rs1_i;
  logic [ADDR_WIDTH-1:0] instr_rs2_i;
  logic [ADDR_WIDTH-1:0] rf_rs1_addr_o;
  logic [ADDR_WIDTH-1:0] rf_rs2_addr_o;
  logic [DATA_WIDTH-1:0] rf_rs1_data_i;
  logic [DATA_WIDTH-1:0] rf_rs2_data_i;
  logic [DATA_WIDTH-1:0] alu_rs1_data_o;
  logic [DATA_WIDTH-1:0] alu_rs2_data_o;
  logic [FUNC_WIDTH-1:0] alu_func_o;
  logic [DATA_WIDTH-1:0] alu_rd_data_i;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_o;
  logic [DATA_WIDTH-1:0] rf_wr_data_o;
  logic                  done_o;

  modport master (
    input  instr_valid_i, instr_func_i, instr_rd_i, instr_rs1_i, instr_rs2_i,
    input  rf_rs1_data_i, rf_rs2_data_i, alu_rd_data_i,
    output instr_ready_o, rf_rs1_addr_o, rf_rs2_addr_o,
    output alu_rs1_data_o, alu_rs2_data_o, alu_func_o,
    output rf_we_o, rf_wr_addr_o, rf_wr_data_o, done_o
  );

  modport slave (
    output instr_valid_i, instr_func_i, instr_rd_i, instr_rs1_i, instr_rs2_i,
    output rf_rs1_data_i, rf_rs2_data_i, alu_rd_data_i,
    input  instr_ready_o, rf_rs1_addr_o, rf_rs2_addr_o,
    input  alu_rs1_data_o, alu_rs2_data_o, alu_func_o,
    input  rf_we_o, rf_wr_addr_o, rf_wr_data_o, done_o
  );
endinterface

// File: rtl/alu_gate_issue.sv
// Gate-ALU issue sequencer IDLE->READ->EXEC->WB: write-back 3 cycles after accept, ready low while busy (1 instr / 4 cycles).
// ALU_GATE_ISSUE_ZERO_REG_EN: register 0 is hard-wired zero, so rd==0 retires without a write.
module alu_gate_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FUNC_WIDTH = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_gate_issue_if.master bus
);

  localparam logic [FUNC_WIDTH-1:0] FUNC_NOT = FUNC_WIDTH'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [FUNC_WIDTH-1:0] func_q, func_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wb_fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.instr_valid_i) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the strobes so an abort in WB never writes or signals completion.
  assign wb_fire = (state_q == WB) && !rst_i;

  always_comb begin
    bus.instr_ready_o = (state_q == IDLE);
    bus.done_o        = wb_fire;
`ifdef ALU_GATE_ISSUE_ZERO_REG_EN
    bus.rf_we_o       = wb_fire && (wr_addr_q != '0);
`else
    bus.rf_we_o       = wb_fire;
`endif
  end

  always_comb begin
    func_d    = func_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid_i) begin
          func_d = bus.instr_func_i;
          rd_d   = bus.instr_rd_i;
          rs1_d  = bus.instr_rs1_i;
          rs2_d  = bus.instr_rs2_i;
        end
      end
      READ: begin
        op1_d = bus.rf_rs1_data_i;
        // NOT is unary; the second operand is forced to zero for the gate unit.
        op2_d = (func_q == FUNC_NOT) ? '0 : bus.rf_rs2_data_i;
      end
      EXEC: begin
        wr_addr_d = rd_q;
        wr_data_d = bus.alu_rd_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      func_q    <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      func_q    <= func_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.rf_rs1_addr_o  = rs1_q;
  assign bus.rf_rs2_addr_o  = rs2_q;
  assign bus.alu_rs1_data_o = op1_q;
  assign bus.alu_rs2_data_o = op2_q;
  assign bus.alu_func_o     = func_q;
  assign bus.rf_wr_addr_o   = wr_addr_q;
  assign bus.rf_wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_alu_gate_issue.sv
// Directed bench for alu_gate_issue with register-file and gate-unit models and a retire scoreboard.
module tb_alu_gate_issue;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_hs = 0;
  exp_t sb[$];

  logic [DW-1:0] rf [32];
  logic [DW-1:0] mr [32];

  alu_gate_issue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUNC_WIDTH(FW)) bus ();

  alu_gate_issue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUNC_WIDTH(FW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      1:       return 32'hF0F0_F0F0;
      2:       return 32'hFF00_FF00;
      4:       return 32'h0000_00FF;
      5:       return 32'h0000_0F0F;
      9:       return 32'h0000_0001;
      10:      return 32'h0000_0003;
      default: return 32'h0;
    endcase
  endfunction

  // Register file: combinational read, write on rf_we_o, reloaded under reset.
  assign bus.rf_rs1_data_i = rf[bus.rf_rs1_addr_o];
  assign bus.rf_rs2_data_i = rf[bus.rf_rs2_addr_o];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    end else if (bus.rf_we_o) begin
      rf[bus.rf_wr_addr_o] <= bus.rf_wr_data_o;
    end
  end

  // Combinational gate unit.
  always_comb begin
    case (bus.alu_func_o)
      2'd0:    bus.alu_rd_data_i = bus.alu_rs1_data_o & bus.alu_rs2_data_o;
      2'd1:    bus.alu_rd_data_i = bus.alu_rs1_data_o | bus.alu_rs2_data_o;
      2'd2:    bus.alu_rd_data_i = bus.alu_rs1_data_o ^ bus.alu_rs2_data_o;
      default: bus.alu_rd_data_i = ~bus.alu_rs1_data_o;
    endcase
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mr[i] = init_val(i);
  endtask

  // Called at a negedge; drives the instruction and waits for the accepting cycle.
  task automatic send(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [DW-1:0] exp_data, input int gap);
    exp_t e;
    bit   got;
    got = 1'b0;
    bus.instr_valid_i = 1'b1;
    bus.instr_func_i  = f;
    bus.instr_rd_i    = rd;
    bus.instr_rs1_i   = rs1;
    bus.instr_rs2_i   = rs2;
    for (int i = 0; i < 16; i++) begin
      if (bus.instr_ready_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("hs_seen", 32'(got), 32'd1);
    if (gap > 0) chk("hs_gap", cyc - last_hs, gap);
    last_hs = cyc;
    e.addr = rd;
    e.data = exp_data;
    e.we   = 1'b1;
`ifdef ALU_GATE_ISSUE_ZERO_REG_EN
    if (rd == 5'd0) e.we = 1'b0;
`endif
    sb.push_back(e);
  endtask

  // Steps READ, EXEC, WB after the accepting cycle and checks each phase.
  task automatic retire(input logic [1:0] f, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit drop_valid);
    exp_t e;
    @(negedge clk);
    chk("read_ready", 32'(bus.instr_ready_o), 32'd0);
    chk("read_we", 32'(bus.rf_we_o), 32'd0);
    chk("read_rs1_addr", 32'(bus.rf_rs1_addr_o), 32'(rs1));
    chk("read_rs2_addr", 32'(bus.rf_rs2_addr_o), 32'(rs2));
    bus.instr_rd_i = 5'd31;
    if (drop_valid) bus.instr_valid_i = 1'b0;
    @(negedge clk);
    chk("exec_func", 32'(bus.alu_func_o), 32'(f));
    chk("exec_op1", bus.alu_rs1_data_o, mr[rs1]);
    chk("exec_op2", bus.alu_rs2_data_o, (f == 2'd3) ? 32'h0 : mr[rs2]);
    chk("exec_done", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    chk("sb_depth", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wb_we", 32'(bus.rf_we_o), 32'(e.we));
      chk("wb_done", 32'(bus.done_o), 32'd1);
      chk("wb_addr", 32'(bus.rf_wr_addr_o), 32'(e.addr));
      chk("wb_data", bus.rf_wr_data_o, e.data);
      if (e.we) mr[e.addr] = e.data;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 32'(bus.instr_ready_o), 32'd1);
    chk({tag, "_we"}, 32'(bus.rf_we_o), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    bus.instr_valid_i = 1'b0;
    bus.instr_func_i  = '0;
    bus.instr_rd_i    = '0;
    bus.instr_rs1_i   = '0;
    bus.instr_rs2_i   = '0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_quiet("rst");
    chk("rst_rs1_addr", 32'(bus.rf_rs1_addr_o), 32'd0);
    chk("rst_rs2_addr", 32'(bus.rf_rs2_addr_o), 32'd0);
    chk("rst_op1", bus.alu_rs1_data_o, 32'h0);
    chk("rst_op2", bus.alu_rs2_data_o, 32'h0);
    chk("rst_func", 32'(bus.alu_func_o), 32'd0);
    chk("rst_wr_addr", 32'(bus.rf_wr_addr_o), 32'd0);
    chk("rst_wr_data", bus.rf_wr_data_o, 32'h0);

    send(2'd0, 5'd3, 5'd1, 5'd2, 32'hF000_F000, 0);
    retire(2'd0, 5'd1, 5'd2, 1'b1);
    @(negedge clk);
    chk_quiet("and_after");

    send(2'd1, 5'd6, 5'd4, 5'd5, 32'h0000_0FFF, 0);
    retire(2'd1, 5'd4, 5'd5, 1'b0);
    send(2'd2, 5'd7, 5'd4, 5'd5, 32'h0000_0FF0, 4);
    retire(2'd2, 5'd4, 5'd5, 1'b0);
    send(2'd3, 5'd8, 5'd4, 5'd5, 32'hFFFF_FF00, 4);
    retire(2'd3, 5'd4, 5'd5, 1'b1);
    @(negedge clk);
    chk_quiet("not_after");

    send(2'd0, 5'd11, 5'd1, 5'd2, 32'hF000_F000, 0);
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("abort");
    chk("abort_wr_addr", 32'(bus.rf_wr_addr_o), 32'd0);
    chk("abort_wr_data", bus.rf_wr_data_o, 32'h0);
    chk("abort_op1", bus.alu_rs1_data_o, 32'h0);
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    model_reset();
    @(negedge clk);
    chk_quiet("abort_next");

    send(2'd0, 5'd12, 5'd1, 5'd2, 32'hF000_F000, 0);
    retire(2'd0, 5'd1, 5'd2, 1'b1);
    @(negedge clk);

    send(2'd2, 5'd0, 5'd9, 5'd10, 32'h0000_0002, 0);
    retire(2'd2, 5'd9, 5'd10, 1'b1);
    @(negedge clk);
    chk_quiet("rd0_after");

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
